shift_issue_stage: RTL and testbench
====================================

// Module: shift_issue_stage
// PURPOSE
// - Pipeline stage directly upstream of the EX-stage barrel shifter.
// - Accepts decoded RV32I shift instructions (SLL/SRL/SRA, SLLI/SRLI/SRAI) from ID.
// - Selects the operands, decodes the shift type, and holds them in a 2-entry skid buffer.
// - Presents registered A/shamt/type to the shifter under a valid/ready handshake.
// - Back-pressure is full-throughput; flush is supported for branch mispredicts.
// PARAMETERS
// - XLEN  32  datapath width; only 32 is supported (shifter fixed at 32 bits, shamt 5 bits)
// PORTS
// - clk            in   1     system clock, rising edge
// - rst_n          in   1     reset, asynchronous, active-low
// - flush          in   1     synchronous kill of all buffered entries
// - in_valid       in   1     ID presents a shift instruction
// - in_ready       out  1     stage can accept this cycle
// - in_rs1         in   XLEN  rs1 value (shift source)
// - in_rs2         in   XLEN  rs2 value (register-form shamt source)
// - in_is_imm      in   1     1 = I-type (SxxI), 0 = R-type
// - in_imm_shamt   in   5     imm[4:0] of an I-type
// - in_funct3      in   3     instruction funct3
// - in_funct7      in   7     funct7 (R-type) or imm[11:5] (I-type)
// - in_rd          in   5     destination register tag
// - out_valid      out  1     head entry valid toward shifter
// - out_ready      in   1     shifter/EX consumes head this cycle
// - out_a          out  XLEN  shift source operand
// - out_shamt      out  5     shift amount
// - out_type       out  2     00 = SRL, 01 = SLL, 10 = SRA (shifter encoding)
// - out_rd         out  5     destination tag, travels with data
// - out_illegal    out  1     head entry is an illegal shift encoding
// BEHAVIOUR
// - Reset: all entries invalid; out_valid = 0; out_a, out_shamt, out_type, out_rd, out_illegal = 0; in_ready = 1.
// - Accept when in_valid && in_ready. Pop when out_valid && out_ready.
// - Decode at accept time:
//   - funct3 = 001 -> type 01.
//   - funct3 = 101 && funct7[5] = 0 -> type 00.
//   - funct3 = 101 && funct7[5] = 1 -> type 10.
//   - Any other funct3 -> type 00.
// - Shamt: in_is_imm ? in_imm_shamt : in_rs2[4:0]. Upper rs2 bits are ignored and never an error.
// - Storage: head register (drives the out_* ports directly) plus one skid register. Outputs are
//   always registered; no combinational path from in_* to out_*.
// - FSM on occupancy:
//   - EMPTY: accept -> ONE (written to head).
//   - ONE: accept and no pop -> TWO (written to skid). Pop and no accept -> EMPTY.
//     Accept and pop -> ONE (new data to head).
//   - TWO: pop -> ONE (skid moves to head). No accept is possible in TWO.
// - in_ready = (state != TWO), registered from state; no dependence on out_ready.
// - Latency: accept at edge N -> out_valid high after edge N; 1 cycle when EMPTY.
// - Ordering is strictly FIFO; head data is stable while out_valid && !out_ready.
// - flush: next edge -> EMPTY.
//   - An accept or pop in the same cycle is discarded.
//   - Data registers may keep stale values; valid is cleared.
// - rst_n low mid-operation drops all entries immediately, asynchronously.
// - Throughput: one instruction per cycle when out_ready is held high.
// CONFIGURATION
// - SHIFT_ILLEGAL_CHECK_EN defined:
//   - out_illegal is set for the stored entry if any of the following holds:
//     - funct3 is not 001 or 101;
//     - funct7 is not 0000000 or 0100000;
//     - funct7 = 0100000 with funct3 = 001.
//   - Illegal entries still flow through the buffer; EX raises the trap.
// - SHIFT_ILLEGAL_CHECK_EN undefined: out_illegal tied to 0; no check logic is built.
// TESTING
// - Reset, then SLLI: rs1 = 0x0000_0001, imm_shamt = 4, funct3 = 001 -> next cycle out_a = 0x1, out_shamt = 4, out_type = 01.
// - SRA reg-form: rs1 = 0x8000_0000, rs2 = 0xFFFF_FFE3, funct3 = 101, funct7 = 0x20 -> out_shamt = 3, out_type = 10.
// - Backpressure: out_ready = 0, push 3 ops -> in_ready drops after 2; drain yields ops 1, 2, then op 3 accepted, order kept.
// - Streaming: in_valid = out_ready = 1 for 10 cycles -> 10 outputs on consecutive cycles, in_ready never drops.
// - Flush with TWO entries plus a simultaneous accept -> next cycle out_valid = 0, in_ready = 1; rst_n pulse mid-stream does the same.
// - With SHIFT_ILLEGAL_CHECK_EN: funct3 = 001, funct7 = 0x20 -> out_illegal = 1; funct7 = 0x01 -> out_illegal = 1; legal SRL -> 0.

Source files
------------

// File: rtl/shift_issue_stage.sv
// Operand-select / shift-type decode stage feeding the EX barrel shifter through a 2-entry skid buffer.
// Optional macro SHIFT_ILLEGAL_CHECK_EN builds the illegal-encoding check driving out_illegal.
module shift_issue_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic            in_is_imm,
    input  logic [4:0]      in_imm_shamt,
    input  logic [2:0]      in_funct3,
    input  logic [6:0]      in_funct7,
    input  logic [4:0]      in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_a,
    output logic [4:0]      out_shamt,
    output logic [1:0]      out_type,
    output logic [4:0]      out_rd,
    output logic            out_illegal
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [4:0]      shamt;
        logic [1:0]      typ;
        logic [4:0]      rd;
        logic            ill;
    } entry_t;

    localparam entry_t ENTRY_ZERO = '{a: {XLEN{1'b0}}, shamt: 5'd0, typ: 2'd0, rd: 5'd0, ill: 1'b0};

    // Shifter encoding: 00 = SRL, 01 = SLL, 10 = SRA.
    function automatic logic [1:0] decode_type(input logic [2:0] f3, input logic f7_b5);
        logic [1:0] t;
        case (f3)
            3'b001:  t = 2'b01;
            3'b101:  t = f7_b5 ? 2'b10 : 2'b00;
            default: t = 2'b00;
        endcase
        return t;
    endfunction

`ifdef SHIFT_ILLEGAL_CHECK_EN
    function automatic logic decode_illegal(input logic [2:0] f3, input logic [6:0] f7);
        logic bad_f3;
        logic bad_f7;
        bad_f3 = (f3 != 3'b001) && (f3 != 3'b101);
        bad_f7 = (f7 != 7'b0000000) && (f7 != 7'b0100000);
        return bad_f3 || bad_f7 || ((f7 == 7'b0100000) && (f3 == 3'b001));
    endfunction
`else
    // Only funct7[5] matters for the type when no legality check is built.
    logic unused_funct7_s;
    assign unused_funct7_s = ^{in_funct7[6], in_funct7[4:0]};
`endif

    // Register-form shamt takes rs2[4:0]; the upper bits are architecturally ignored.
    logic unused_rs2_s;
    assign unused_rs2_s = ^in_rs2[XLEN-1:5];

    state_e state_q, state_d;
    entry_t head_q, head_d;
    entry_t skid_q, skid_d;
    entry_t new_entry_s;
    logic   in_ready_q, in_ready_d;
    logic   out_valid_q, out_valid_d;
    logic   accept_s;
    logic   pop_s;

    // Operand selection and decode of the incoming instruction.
    always_comb begin
        new_entry_s       = ENTRY_ZERO;
        new_entry_s.a     = in_rs1;
        new_entry_s.shamt = in_is_imm ? in_imm_shamt : in_rs2[4:0];
        new_entry_s.typ   = decode_type(in_funct3, in_funct7[5]);
        new_entry_s.rd    = in_rd;
`ifdef SHIFT_ILLEGAL_CHECK_EN
        new_entry_s.ill   = decode_illegal(in_funct3, in_funct7);
`else
        new_entry_s.ill   = 1'b0;
`endif
    end

    // Occupancy FSM next-state and skid-buffer data movement.
    always_comb begin
        state_d  = state_q;
        head_d   = head_q;
        skid_d   = skid_q;
        accept_s = in_valid && in_ready_q;
        pop_s    = out_valid_q && out_ready;
        if (flush) begin
            // Data may go stale; only occupancy is cleared.
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_s) begin
                        head_d  = new_entry_s;
                        state_d = ST_ONE;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && pop_s) begin
                        head_d  = new_entry_s;
                        state_d = ST_ONE;
                    end else if (accept_s) begin
                        skid_d  = new_entry_s;
                        state_d = ST_TWO;
                    end else if (pop_s) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_TWO: begin
                    if (pop_s) begin
                        head_d  = skid_q;
                        state_d = ST_ONE;
                    end else begin
                        state_d = ST_TWO;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
        in_ready_d  = (state_d != ST_TWO);
        out_valid_d = (state_d != ST_EMPTY);
    end

    // State, data and handshake flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            head_q      <= ENTRY_ZERO;
            skid_q      <= ENTRY_ZERO;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_a       = head_q.a;
    assign out_shamt   = head_q.shamt;
    assign out_type    = head_q.typ;
    assign out_rd      = head_q.rd;
    assign out_illegal = head_q.ill;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Randomized + directed bench for shift_issue_stage against a queue-based reference model.
module tb_shift_issue_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic        in_is_imm;
    logic [4:0]  in_imm_shamt;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a;
    logic [4:0]  out_shamt;
    logic [1:0]  out_type;
    logic [4:0]  out_rd;
    logic        out_illegal;

    shift_issue_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_is_imm(in_is_imm),
        .in_imm_shamt(in_imm_shamt), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_shamt(out_shamt), .out_type(out_type),
        .out_rd(out_rd), .out_illegal(out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [4:0]  shamt;
        logic [1:0]  typ;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    exp_t model_q[$];
    int   checks_cnt;
    int   fail_cnt;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t make_exp(input logic [31:0] rs1, input logic [31:0] rs2,
                                      input logic imm, input logic [4:0] ish,
                                      input logic [2:0] f3, input logic [6:0] f7,
                                      input logic [4:0] rd);
        exp_t e;
        int   amt;
        e.a  = rs1;
        amt  = imm ? int'(ish) : int'(rs2 % 32);
        e.shamt = amt[4:0];
        if (f3 == 3'd1)                  e.typ = 2'd1;
        else if (f3 == 3'd5 && f7 >= 7'd32 && (f7 / 32) % 2 == 1) e.typ = 2'd2;
        else                              e.typ = 2'd0;
        e.rd = rd;
`ifdef SHIFT_ILLEGAL_CHECK_EN
        e.ill = !(f3 == 3'd1 || f3 == 3'd5) || !(f7 == 7'd0 || f7 == 7'd32) ||
                (f7 == 7'd32 && f3 == 3'd1);
`else
        e.ill = 1'b0;
`endif
        return e;
    endfunction

    task automatic check_outputs(input string tag);
        check_eq({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, model_q.size() < 2});
        check_eq({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, model_q.size() > 0});
        if (model_q.size() > 0) begin
            check_eq({tag, ".out_a"}, out_a, model_q[0].a);
            check_eq({tag, ".out_shamt"}, {27'd0, out_shamt}, {27'd0, model_q[0].shamt});
            check_eq({tag, ".out_type"}, {30'd0, out_type}, {30'd0, model_q[0].typ});
            check_eq({tag, ".out_rd"}, {27'd0, out_rd}, {27'd0, model_q[0].rd});
            check_eq({tag, ".out_illegal"}, {31'd0, out_illegal}, {31'd0, model_q[0].ill});
        end
    endtask

    // Drive one cycle of stimulus, advance the model at the edge, check at the next negedge.
    task automatic cycle(input string tag, input logic v, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic imm, input logic [4:0] ish, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [4:0] rd, input logic ordy, input logic fl);
        bit acc;
        bit pop;
        in_valid = v; in_rs1 = rs1; in_rs2 = rs2; in_is_imm = imm; in_imm_shamt = ish;
        in_funct3 = f3; in_funct7 = f7; in_rd = rd; out_ready = ordy; flush = fl;
        acc = v && (model_q.size() < 2);
        pop = ordy && (model_q.size() > 0);
        @(posedge clk);
        if (fl) begin
            model_q.delete();
        end else begin
            if (pop) void'(model_q.pop_front());
            if (acc) model_q.push_back(make_exp(rs1, rs2, imm, ish, f3, f7, rd));
        end
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_rs1 = 32'd0; in_rs2 = 32'd0; in_is_imm = 1'b0; in_imm_shamt = 5'd0;
        in_funct3 = 3'd0; in_funct7 = 7'd0; in_rd = 5'd0; out_ready = 1'b0; flush = 1'b0;
    endtask

    task automatic pulse_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_q.delete();
        check_eq({tag, ".rst_out_valid"}, {31'd0, out_valid}, 32'd0);
        check_eq({tag, ".rst_in_ready"}, {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [2:0] f3_r;
        logic [6:0] f7_r;
        checks_cnt = 0;
        fail_cnt   = 0;
        rst_n      = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        check_eq("reset.out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("reset.in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("reset.out_a", out_a, 32'd0);
        check_eq("reset.out_shamt", {27'd0, out_shamt}, 32'd0);
        check_eq("reset.out_type", {30'd0, out_type}, 32'd0);
        check_eq("reset.out_rd", {27'd0, out_rd}, 32'd0);
        check_eq("reset.out_illegal", {31'd0, out_illegal}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // SLLI x?, 1, 4
        cycle("slli", 1'b1, 32'h0000_0001, 32'hDEAD_BEEF, 1'b1, 5'd4, 3'b001, 7'h00, 5'd3, 1'b0, 1'b0);
        check_eq("slli.a_const", out_a, 32'h0000_0001);
        check_eq("slli.shamt_const", {27'd0, out_shamt}, 32'd4);
        check_eq("slli.type_const", {30'd0, out_type}, 32'd1);
        check_eq("slli.valid_const", {31'd0, out_valid}, 32'd1);
        cycle("slli_pop", 1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 3'd0, 7'd0, 5'd0, 1'b1, 1'b0);

        // SRA register form, shamt from rs2[4:0]
        cycle("sra", 1'b1, 32'h8000_0000, 32'hFFFF_FFE3, 1'b0, 5'd17, 3'b101, 7'h20, 5'd9, 1'b0, 1'b0);
        check_eq("sra.shamt_const", {27'd0, out_shamt}, 32'd3);
        check_eq("sra.type_const", {30'd0, out_type}, 32'd2);
        cycle("sra_pop", 1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 3'd0, 7'd0, 5'd0, 1'b1, 1'b0);

        // Backpressure: three pushes with out_ready low, then drain
        cycle("bp1", 1'b1, 32'h11, 32'd1, 1'b0, 5'd0, 3'b101, 7'h00, 5'd1, 1'b0, 1'b0);
        cycle("bp2", 1'b1, 32'h22, 32'd2, 1'b0, 5'd0, 3'b101, 7'h00, 5'd2, 1'b0, 1'b0);
        check_eq("bp.in_ready_low", {31'd0, in_ready}, 32'd0);
        cycle("bp3", 1'b1, 32'h33, 32'd3, 1'b0, 5'd0, 3'b101, 7'h00, 5'd3, 1'b0, 1'b0);
        check_eq("bp.head_op1", {27'd0, out_rd}, 32'd1);
        cycle("bp_d1", 1'b1, 32'h33, 32'd3, 1'b0, 5'd0, 3'b101, 7'h00, 5'd3, 1'b1, 1'b0);
        check_eq("bp.head_op2", {27'd0, out_rd}, 32'd2);
        cycle("bp_d2", 1'b1, 32'h33, 32'd3, 1'b0, 5'd0, 3'b101, 7'h00, 5'd3, 1'b1, 1'b0);
        check_eq("bp.head_op3", {27'd0, out_rd}, 32'd3);
        cycle("bp_d3", 1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 3'd0, 7'd0, 5'd0, 1'b1, 1'b0);
        check_eq("bp.drained", {31'd0, out_valid}, 32'd0);

        // Streaming at full throughput
        for (int i = 0; i < 10; i++) begin
            cycle("stream", 1'b1, 32'h100 + 32'(i), 32'(i), 1'b0, 5'd0, 3'b001, 7'h00, 5'(i), 1'b1, 1'b0);
            check_eq("stream.in_ready", {31'd0, in_ready}, 32'd1);
            check_eq("stream.rd_seq", {27'd0, out_rd}, 32'(i));
        end
        cycle("stream_end", 1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 3'd0, 7'd0, 5'd0, 1'b1, 1'b0);

        // Flush with two entries plus an offered instruction
        cycle("fl_a", 1'b1, 32'hA, 32'd0, 1'b1, 5'd1, 3'b001, 7'h00, 5'd10, 1'b0, 1'b0);
        cycle("fl_b", 1'b1, 32'hB, 32'd0, 1'b1, 5'd2, 3'b001, 7'h00, 5'd11, 1'b0, 1'b0);
        cycle("fl_go", 1'b1, 32'hC, 32'd0, 1'b1, 5'd3, 3'b001, 7'h00, 5'd12, 1'b1, 1'b1);
        check_eq("flush.out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("flush.in_ready", {31'd0, in_ready}, 32'd1);
        cycle("fl_one", 1'b1, 32'hD, 32'd0, 1'b1, 5'd4, 3'b001, 7'h00, 5'd13, 1'b0, 1'b0);
        cycle("fl_one_go", 1'b1, 32'hE, 32'd0, 1'b1, 5'd5, 3'b001, 7'h00, 5'd14, 1'b1, 1'b1);
        check_eq("flush1.out_valid", {31'd0, out_valid}, 32'd0);

        // Async reset mid-stream with two entries
        cycle("rs_a", 1'b1, 32'h5, 32'd0, 1'b1, 5'd1, 3'b101, 7'h20, 5'd20, 1'b0, 1'b0);
        cycle("rs_b", 1'b1, 32'h6, 32'd0, 1'b1, 5'd1, 3'b101, 7'h20, 5'd21, 1'b0, 1'b0);
        pulse_reset("midreset");
        check_outputs("post_reset");

`ifdef SHIFT_ILLEGAL_CHECK_EN
        cycle("ill_slli_f7", 1'b1, 32'h1, 32'd0, 1'b1, 5'd1, 3'b001, 7'h20, 5'd1, 1'b1, 1'b0);
        check_eq("ill.f7_20_sll", {31'd0, out_illegal}, 32'd1);
        cycle("ill_f7_01", 1'b1, 32'h1, 32'd0, 1'b1, 5'd1, 3'b101, 7'h01, 5'd2, 1'b1, 1'b0);
        check_eq("ill.f7_01", {31'd0, out_illegal}, 32'd1);
        cycle("ill_srl_ok", 1'b1, 32'h1, 32'd0, 1'b0, 5'd1, 3'b101, 7'h00, 5'd3, 1'b1, 1'b0);
        check_eq("ill.srl_legal", {31'd0, out_illegal}, 32'd0);
        cycle("ill_end", 1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 3'd0, 7'd0, 5'd0, 1'b1, 1'b0);
`endif

        // Randomized traffic against the queue model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                pulse_reset("rand_reset");
            end
            case ($urandom_range(0, 3))
                0:       f3_r = 3'($urandom_range(0, 7));
                1, 2:    f3_r = 3'b101;
                default: f3_r = 3'b001;
            endcase
            case ($urandom_range(0, 3))
                0:       f7_r = 7'($urandom_range(0, 127));
                1:       f7_r = 7'h20;
                default: f7_r = 7'h00;
            endcase
            cycle("rand", 1'($urandom_range(0, 3) != 0), $urandom, $urandom, 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 31)), f3_r, f7_r, 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 49) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
